// File: rtl/microroc_asic_emulator_if.sv
// DAQ-controller <-> MICROROC emulator pin bundle.
// master = DAQ controller side, slave = emulated ASIC side.
interface microroc_asic_emulator_if;
  logic        RESET_B;
  logic        PWR_ON_D;
  logic        START_ACQ;
  logic        StartReadout;
  logic        HitTrigger;
  logic [7:0]  ChipId;
  logic        CHIPSATB;
  logic        EndReadout;
  logic [15:0] MicrorocData;
  logic        MicrorocData_en;
  logic [7:0]  HitOverflow;

  modport master (
    output RESET_B, PWR_ON_D, START_ACQ, StartReadout, HitTrigger, ChipId,
    input  CHIPSATB, EndReadout, MicrorocData, MicrorocData_en, HitOverflow
  );

  modport slave (
    input  RESET_B, PWR_ON_D, START_ACQ, StartReadout, HitTrigger, ChipId,
    output CHIPSATB, EndReadout, MicrorocData, MicrorocData_en, HitOverflow
  );
endinterface

// File: rtl/microroc_asic_emulator.sv
// Behavioural MICROROC stand-in: records {BCID, LFSR} hit frames during an
// acquisition window and replays them as a strobed 16-bit word stream.
// Optional macro EMU_PARITY_WORD_EN adds a fourth word (W0^W1^W2) per frame.
module microroc_asic_emulator #(
  parameter int unsigned MEM_DEPTH   = 8,
  parameter int unsigned CONV_CYCLES = 32,
  parameter int unsigned END_HOLD    = 4,
  parameter int unsigned BCID_DIV    = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                     Clk,
  input logic                     reset_n,
  microroc_asic_emulator_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACQ, CONVERT, WAIT_SRO, READOUT, END_RO} state_t;

  localparam logic [3:0]  DEPTH      = 4'(MEM_DEPTH);
  localparam logic [3:0]  DEPTH_LAST = 4'(MEM_DEPTH - 1);
  localparam logic [15:0] CONV_LAST  = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(END_HOLD - 1);
  localparam logic [15:0] DIV_LAST   = 16'(BCID_DIV - 1);
`ifdef EMU_PARITY_WORD_EN
  localparam logic [1:0]  LAST_WORD  = 2'd3;
`else
  localparam logic [1:0]  LAST_WORD  = 2'd2;
`endif

  // Synchroniser stages: r1 is the first flop, r2 the second.
  logic rstb_r1_q, rstb_r2_q;
  logic acq_r1_q,  acq_r2_q;
  logic sro_r1_q,  sro_r2_q;
  logic hit_r1_q,  hit_r2_q;

  state_t      state_q;
  logic [3:0]  count_q;
  logic [3:0]  frame_q;
  logic [1:0]  word_q;
  logic        gap_q;
  logic [15:0] tmr_q;
  logic [15:0] div_q;
  logic [15:0] bcid_q;
  logic [15:0] lfsr_q;
  logic [7:0]  ovf_q;
  logic        chipsatb_q;
  logic        endro_q;
  logic [15:0] data_q;
  logic        data_en_q;

  logic [15:0] mem_bcid [MEM_DEPTH];
  logic [15:0] mem_lfsr [MEM_DEPTH];

  logic        soft_rst;
  logic        acq_rise, acq_fall, sro_rise, hit_rise;
  logic        hit_ok, store_en, ovf_inc;
  logic [15:0] word_d;

  assign soft_rst = ~rstb_r2_q | ~bus.PWR_ON_D;
  assign acq_rise = acq_r1_q & ~acq_r2_q;
  assign acq_fall = ~acq_r1_q & acq_r2_q;
  assign sro_rise = sro_r1_q & ~sro_r2_q;
  assign hit_rise = hit_r1_q & ~hit_r2_q;

  // A hit coinciding with the stop edge is discarded outright.
  assign hit_ok   = (state_q == ACQ) & hit_rise & ~acq_fall & ~soft_rst;
  assign store_en = hit_ok & (count_q < DEPTH);
  assign ovf_inc  = hit_ok & (count_q >= DEPTH);

  // Two-flop synchronisers for the asynchronous controller pins.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      rstb_r1_q <= 1'b1;
      rstb_r2_q <= 1'b1;
      acq_r1_q  <= 1'b0;
      acq_r2_q  <= 1'b0;
      sro_r1_q  <= 1'b0;
      sro_r2_q  <= 1'b0;
      hit_r1_q  <= 1'b0;
      hit_r2_q  <= 1'b0;
    end else begin
      rstb_r1_q <= bus.RESET_B;
      rstb_r2_q <= rstb_r1_q;
      acq_r1_q  <= bus.START_ACQ;
      acq_r2_q  <= acq_r1_q;
      sro_r1_q  <= bus.StartReadout;
      sro_r2_q  <= sro_r1_q;
      hit_r1_q  <= bus.HitTrigger;
      hit_r2_q  <= hit_r1_q;
    end
  end

  // Free-running hit-pattern LFSR (x^16+x^14+x^13+x^11); survives soft reset.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Saturating count of hits dropped while memory is full; only reset_n clears it.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)                      ovf_q <= 8'h00;
    else if (ovf_inc && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'h01;
  end

  // Frame memory: pure storage, contents are qualified by count_q.
  always_ff @(posedge Clk) begin
    if (store_en) begin
      mem_bcid[count_q[2:0]] <= bcid_q;
      mem_lfsr[count_q[2:0]] <= lfsr_q;
    end
  end

  // Select the word of the current frame to be emitted next.
  always_comb begin
    word_d = {bus.ChipId, 5'b0, frame_q[2:0]};
    case (word_q)
      2'd1:    word_d = mem_bcid[frame_q[2:0]];
      2'd2:    word_d = mem_lfsr[frame_q[2:0]];
`ifdef EMU_PARITY_WORD_EN
      2'd3:    word_d = {bus.ChipId, 5'b0, frame_q[2:0]}
                        ^ mem_bcid[frame_q[2:0]] ^ mem_lfsr[frame_q[2:0]];
`endif
      default: word_d = {bus.ChipId, 5'b0, frame_q[2:0]};
    endcase
  end

  // Acquisition / conversion / readout sequencer with registered outputs.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      frame_q    <= 4'd0;
      word_q     <= 2'd0;
      gap_q      <= 1'b0;
      tmr_q      <= 16'd0;
      div_q      <= 16'd0;
      bcid_q     <= 16'd0;
      chipsatb_q <= 1'b1;
      endro_q    <= 1'b0;
      data_q     <= 16'd0;
      data_en_q  <= 1'b0;
    end else if (soft_rst) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      frame_q    <= 4'd0;
      word_q     <= 2'd0;
      gap_q      <= 1'b0;
      tmr_q      <= 16'd0;
      div_q      <= 16'd0;
      bcid_q     <= 16'd0;
      chipsatb_q <= 1'b1;
      endro_q    <= 1'b0;
      data_q     <= 16'd0;
      data_en_q  <= 1'b0;
    end else begin
      data_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acq_rise) begin
            state_q <= ACQ;
            count_q <= 4'd0;
            bcid_q  <= 16'd0;
            div_q   <= 16'd0;
          end
        end
        ACQ: begin
          if (div_q == DIV_LAST) begin
            div_q  <= 16'd0;
            bcid_q <= bcid_q + 16'd1;
          end else begin
            div_q  <= div_q + 16'd1;
          end
          if (acq_fall) begin
            state_q    <= CONVERT;
            chipsatb_q <= 1'b0;
            tmr_q      <= 16'd0;
          end else if (store_en) begin
            count_q <= count_q + 4'd1;
            if (count_q == DEPTH_LAST) chipsatb_q <= 1'b0;
          end
        end
        CONVERT: begin
          if (tmr_q == CONV_LAST) begin
            chipsatb_q <= 1'b1;
            state_q    <= WAIT_SRO;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        WAIT_SRO: begin
          if (sro_rise) begin
            state_q <= READOUT;
            frame_q <= 4'd0;
            word_q  <= 2'd0;
            gap_q   <= 1'b0;
          end
        end
        READOUT: begin
          if (count_q == 4'd0) begin
            state_q <= END_RO;
            endro_q <= 1'b1;
            tmr_q   <= 16'd0;
          end else if (!gap_q) begin
            data_q    <= word_d;
            data_en_q <= 1'b1;
            gap_q     <= 1'b1;
          end else begin
            gap_q <= 1'b0;
            if (word_q == LAST_WORD) begin
              word_q <= 2'd0;
              if (frame_q == count_q - 4'd1) begin
                state_q <= END_RO;
                endro_q <= 1'b1;
                tmr_q   <= 16'd0;
              end else begin
                frame_q <= frame_q + 4'd1;
              end
            end else begin
              word_q <= word_q + 2'd1;
            end
          end
        end
        END_RO: begin
          if (tmr_q == HOLD_LAST) begin
            endro_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CHIPSATB        = chipsatb_q;
  assign bus.EndReadout      = endro_q;
  assign bus.MicrorocData    = data_q;
  assign bus.MicrorocData_en = data_en_q;
  assign bus.HitOverflow     = ovf_q;

endmodule

// File: tb/tb_microroc_asic_emulator.sv
// Directed bench for microroc_asic_emulator: no-hit run, three hits, memory
// full with overflow, soft reset mid-readout, hit/stop collision, and the
// optional parity word when EMU_PARITY_WORD_EN is defined.
module tb_microroc_asic_emulator;

`ifdef EMU_PARITY_WORD_EN
  localparam int WPF = 4;
`else
  localparam int WPF = 3;
`endif

  logic Clk = 1'b0;
  logic reset_n;
  always #5 Clk = ~Clk;

  microroc_asic_emulator_if bus ();

  microroc_asic_emulator dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] rd_q [$];
  int          rd_hold;
  bit          rd_late;
  bit          rd_timeout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse_hit();
    bus.HitTrigger = 1'b1;
    tick(3);
    bus.HitTrigger = 1'b0;
    tick(3);
  endtask

  // Returns the number of sampled cycles CHIPSATB stayed low, or -1 on timeout.
  task automatic wait_conv(output int low);
    int guard;
    guard = 0;
    while (bus.CHIPSATB !== 1'b0 && guard < 20) begin
      guard++;
      tick(1);
    end
    low = 0;
    while (bus.CHIPSATB === 1'b0 && low < 200) begin
      low++;
      tick(1);
    end
    if (guard >= 20 || low >= 200) low = -1;
  endtask

  task automatic do_readout(input string tag);
    rd_q.delete();
    rd_hold    = 0;
    rd_late    = 1'b0;
    rd_timeout = 1'b1;
    bus.StartReadout = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (i == 3) bus.StartReadout = 1'b0;
      if (bus.MicrorocData_en) begin
        rd_q.push_back(bus.MicrorocData);
        if (rd_hold > 0) rd_late = 1'b1;
      end
      if (bus.EndReadout) rd_hold++;
      else if (rd_hold > 0) begin
        rd_timeout = 1'b0;
        break;
      end
    end
    bus.StartReadout = 1'b0;
    check_eq({tag, "_ro_done"}, {31'd0, rd_timeout}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int cnt;
    bus.RESET_B      = 1'b1;
    bus.PWR_ON_D     = 1'b1;
    bus.START_ACQ    = 1'b0;
    bus.StartReadout = 1'b0;
    bus.HitTrigger   = 1'b0;
    bus.ChipId       = 8'h00;
    reset_n = 1'b0;
    tick(3);
    check_eq("rst_chipsatb", {31'd0, bus.CHIPSATB}, 32'd1);
    check_eq("rst_endro",    {31'd0, bus.EndReadout}, 32'd0);
    check_eq("rst_data",     {16'd0, bus.MicrorocData}, 32'd0);
    check_eq("rst_data_en",  {31'd0, bus.MicrorocData_en}, 32'd0);
    check_eq("rst_ovf",      {24'd0, bus.HitOverflow}, 32'd0);
    reset_n = 1'b1;
    tick(3);

    // T1: acquisition with no hits
    bus.START_ACQ = 1'b1;
    tick(100);
    bus.START_ACQ = 1'b0;
    wait_conv(low);
    check_eq("t1_conv_low", low, 32'd32);
    tick(3);
    do_readout("t1");
    check_eq("t1_strobes", rd_q.size(), 32'd0);
    check_eq("t1_end_hold", rd_hold, 32'd4);
    tick(5);

    // T2: three hits
    bus.ChipId    = 8'h12;
    bus.START_ACQ = 1'b1;
    tick(10);
    repeat (3) pulse_hit();
    tick(5);
    bus.START_ACQ = 1'b0;
    wait_conv(low);
    check_eq("t2_conv_low", low, 32'd32);
    tick(3);
    do_readout("t2");
    check_eq("t2_strobes", rd_q.size(), 3 * WPF);
    if (rd_q.size() == 3 * WPF) begin
      check_eq("t2_w0_f0", rd_q[0], 32'h1200);
      check_eq("t2_w0_f1", rd_q[WPF], 32'h1201);
      check_eq("t2_w0_f2", rd_q[2*WPF], 32'h1202);
      check_eq("t2_bcid_f1_ge_f0", {31'd0, rd_q[WPF+1] >= rd_q[1]}, 32'd1);
      check_eq("t2_bcid_f2_ge_f1", {31'd0, rd_q[2*WPF+1] >= rd_q[WPF+1]}, 32'd1);
      check_eq("t2_lfsr_nonzero", {31'd0, rd_q[2] != 16'h0000}, 32'd1);
`ifdef EMU_PARITY_WORD_EN
      check_eq("t6_parity_f0", rd_q[3], rd_q[0] ^ rd_q[1] ^ rd_q[2]);
      check_eq("t6_parity_f2", rd_q[2*WPF+3], rd_q[2*WPF] ^ rd_q[2*WPF+1] ^ rd_q[2*WPF+2]);
`endif
    end
    check_eq("t2_end_after_last", {31'd0, rd_late}, 32'd0);
    check_eq("t2_end_hold", rd_hold, 32'd4);
    tick(5);

    // T3: ten hits into an eight-frame memory
    bus.ChipId    = 8'h34;
    bus.START_ACQ = 1'b1;
    tick(10);
    for (int h = 0; h < 10; h++) begin
      if (h == 7) begin
        bus.HitTrigger = 1'b1;
        tick(1);
        check_eq("t3_full_not_yet", {31'd0, bus.CHIPSATB}, 32'd1);
        tick(1);
        check_eq("t3_full_fall", {31'd0, bus.CHIPSATB}, 32'd0);
        tick(1);
        bus.HitTrigger = 1'b0;
        tick(3);
      end else begin
        pulse_hit();
      end
    end
    tick(5);
    check_eq("t3_ovf", {24'd0, bus.HitOverflow}, 32'd2);
    bus.START_ACQ = 1'b0;
    wait_conv(low);
    check_eq("t3_conv_done", {31'd0, low > 0}, 32'd1);
    tick(3);
    do_readout("t3");
    check_eq("t3_strobes", rd_q.size(), 8 * WPF);
    if (rd_q.size() == 8 * WPF) check_eq("t3_w0_f7", rd_q[7*WPF], 32'h3407);
    tick(5);

    // T4: RESET_B pulled low during the fourth readout word
    bus.ChipId    = 8'h56;
    bus.START_ACQ = 1'b1;
    tick(10);
    repeat (3) pulse_hit();
    tick(5);
    bus.START_ACQ = 1'b0;
    wait_conv(low);
    tick(3);
    cnt = 0;
    bus.StartReadout = 1'b1;
    for (int i = 0; i < 200 && cnt < 4; i++) begin
      tick(1);
      if (i == 3) bus.StartReadout = 1'b0;
      if (bus.MicrorocData_en) cnt++;
    end
    bus.StartReadout = 1'b0;
    check_eq("t4_reached_w4", cnt, 32'd4);
    bus.RESET_B = 1'b0;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.MicrorocData_en) cnt++;
    end
    check_eq("t4_strobes_stop", cnt, 32'd0);
    check_eq("t4_chipsatb", {31'd0, bus.CHIPSATB}, 32'd1);
    check_eq("t4_endro", {31'd0, bus.EndReadout}, 32'd0);
    bus.RESET_B = 1'b1;
    tick(5);
    check_eq("t4_ovf_kept", {24'd0, bus.HitOverflow}, 32'd2);
    bus.START_ACQ = 1'b1;
    tick(10);
    pulse_hit();
    tick(5);
    bus.START_ACQ = 1'b0;
    wait_conv(low);
    check_eq("t4_conv_low", low, 32'd32);
    tick(3);
    do_readout("t4");
    check_eq("t4_strobes_after", rd_q.size(), WPF);
    if (rd_q.size() == WPF) check_eq("t4_w0_index0", rd_q[0], 32'h5600);
    tick(5);

    // T5: hit edge coincident with START_ACQ falling edge
    bus.ChipId    = 8'h78;
    bus.START_ACQ = 1'b1;
    tick(10);
    pulse_hit();
    tick(5);
    bus.HitTrigger = 1'b1;
    bus.START_ACQ  = 1'b0;
    tick(3);
    bus.HitTrigger = 1'b0;
    wait_conv(low);
    check_eq("t5_ovf_unchanged", {24'd0, bus.HitOverflow}, 32'd2);
    tick(3);
    do_readout("t5");
    check_eq("t5_strobes", rd_q.size(), WPF);
    if (rd_q.size() == WPF) check_eq("t5_w0", rd_q[0], 32'h7800);
    check_eq("t5_end_hold", rd_hold, 32'd4);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
